// File: rtl/cvw_pkg.sv
// Shared tracer package: AXI word width, channel limit and host-command FSM states.
package cvw;

    localparam int RVVI_AXI_WORD    = 32;
    localparam int HOSTCMD_MAX_CMDS = 8;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        DRAIN
    } hostcmd_state_t;

endpackage

// File: rtl/rvvi_host_cmd_decoder_matcher.sv
// Combinational compare of one received beat against header word k of every channel.
// A partially strobed beat never matches; an index past the header never matches.
module hostcmd_matcher
    import cvw::*;
#(
    parameter int NUM_CMDS  = 3,
    parameter int HDR_WORDS = 5,
    parameter int CNT_W     = 3
) (
    input  logic [NUM_CMDS*HDR_WORDS*RVVI_AXI_WORD-1:0] compare_strings_i,
    input  logic [CNT_W-1:0]                            word_idx_i,
    input  logic [RVVI_AXI_WORD-1:0]                    rdata_i,
    input  logic [3:0]                                  rstrb_i,
    output logic [NUM_CMDS-1:0]                         eq_o
);

    // Per-channel equality of the beat with that channel's word k.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        eq_o = '0;
        for (int c = 0; c < NUM_CMDS; c++) begin
            if (int'(word_idx_i) < HDR_WORDS) begin
                eq_o[c] = (rstrb_i == 4'hF) &&
                          (rdata_i == compare_strings_i[(c*HDR_WORDS + int'(word_idx_i))*RVVI_AXI_WORD +: RVVI_AXI_WORD]);
            end
        end
    end

endmodule

// File: rtl/rvvi_host_cmd_decoder.sv
// Host-command decoder: matches frame headers on the MAC receive stream against
// NUM_CMDS programmable strings, captures the payload of a matching frame and
// commits it to the lowest-index matching channel with a one-cycle hit pulse.
module rvvi_host_cmd_decoder
    import cvw::*;
#(
    parameter int NUM_CMDS      = 3,
    parameter int HDR_WORDS     = 5,
    parameter int PAYLOAD_WORDS = 1,
    parameter logic [NUM_CMDS*PAYLOAD_WORDS*RVVI_AXI_WORD-1:0] MSG_RESET = '0
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_CMDS*HDR_WORDS*RVVI_AXI_WORD-1:0]     CompareStrings,
    input  logic [NUM_CMDS-1:0]                             CmdEnable,
    input  logic [RVVI_AXI_WORD-1:0]                        RvviAxiRdata,
    input  logic [3:0]                                      RvviAxiRstrb,
    input  logic                                            RvviAxiRlast,
    input  logic                                            RvviAxiRvalid,
    output logic [NUM_CMDS-1:0]                             CmdHit,
    output logic [NUM_CMDS*PAYLOAD_WORDS*RVVI_AXI_WORD-1:0] CmdMessage,
    output logic                                            BadFrame
);

    localparam int MAX_WORDS = (HDR_WORDS > PAYLOAD_WORDS) ? HDR_WORDS : PAYLOAD_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int SHD_W     = PAYLOAD_WORDS * RVVI_AXI_WORD;
    localparam int MSG_W     = NUM_CMDS * SHD_W;
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_WORDS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_WORDS - 1);

    hostcmd_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CMDS-1:0] match_q, match_d;
    logic [SHD_W-1:0]    shadow_q, shadow_d, shadow_wr;
    logic [MSG_W-1:0]    msg_q, msg_d;
    logic [NUM_CMDS-1:0] hit_q, hit_d;
    logic                bad_q, bad_d;

    logic [CNT_W-1:0]    word_idx;
    logic [NUM_CMDS-1:0] eq;
    logic [NUM_CMDS-1:0] match_first;
    logic [NUM_CMDS-1:0] match_next;
    logic [NUM_CMDS-1:0] commit_sel;

    assign word_idx    = (state_q == IDLE) ? '0 : cnt_q;
    assign match_first = CmdEnable & eq;
    assign match_next  = match_q & eq;

    hostcmd_matcher #(
        .NUM_CMDS  (NUM_CMDS),
        .HDR_WORDS (HDR_WORDS),
        .CNT_W     (CNT_W)
    ) u_matcher (
        .compare_strings_i (CompareStrings),
        .word_idx_i        (word_idx),
        .rdata_i           (RvviAxiRdata),
        .rstrb_i           (RvviAxiRstrb),
        .eq_o              (eq)
    );

    // One-hot select of the lowest-index surviving channel (fixed priority).
    always_comb begin
        commit_sel = '0;
        for (int c = NUM_CMDS - 1; c >= 0; c--) begin
            if (match_q[c]) commit_sel = NUM_CMDS'(1) << c;
        end
    end

    // Shadow payload with the current beat written into word cnt_q.
    always_comb begin
        shadow_wr = shadow_q;
        if (int'(cnt_q) < PAYLOAD_WORDS) begin
            shadow_wr[int'(cnt_q)*RVVI_AXI_WORD +: RVVI_AXI_WORD] = RvviAxiRdata;
        end
    end

    // Next-state, counter, match, shadow, commit and pulse logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        shadow_d = shadow_q;
        msg_d    = msg_q;
        hit_d    = '0;
        bad_d    = 1'b0;
        if (RvviAxiRvalid) begin
            unique case (state_q)
                IDLE: begin
                    match_d = match_first;
                    if (RvviAxiRlast) begin
                        match_d = '0;
                    end else if (HDR_WORDS == 1) begin
                        state_d = (match_first != '0) ? PAY : DRAIN;
                    end else begin
                        state_d = HDR;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HDR: begin
                    match_d = match_next;
                    if (RvviAxiRlast) begin
                        state_d = IDLE;
                        match_d = '0;
                        cnt_d   = '0;
                    end else if (match_next == '0) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else if (cnt_q == HDR_LAST) begin
                        state_d = PAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAY: begin
                    shadow_d = shadow_wr;
                    if (cnt_q == PAY_LAST) begin
                        for (int c = 0; c < NUM_CMDS; c++) begin
                            if (commit_sel[c]) msg_d[c*SHD_W +: SHD_W] = shadow_wr;
                        end
                        hit_d   = commit_sel;
                        state_d = RvviAxiRlast ? IDLE : DRAIN;
                        match_d = '0;
                        cnt_d   = '0;
                    end else if (RvviAxiRlast) begin
                        bad_d   = 1'b1;
                        state_d = IDLE;
                        match_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (RvviAxiRlast) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    match_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Control state, committed messages and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            match_q <= '0;
            msg_q   <= MSG_RESET;
            hit_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            msg_q   <= msg_d;
            hit_q   <= hit_d;
            bad_q   <= bad_d;
        end
    end

    // Payload shadow register.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is pure datapath with no reset; every word is rewritten in a frame before it can be committed.
        shadow_q <= shadow_d;
    end

    assign CmdHit     = hit_q;
    assign CmdMessage = msg_q;
    assign BadFrame   = bad_q;

endmodule

// File: tb/tb_rvvi_host_cmd_decoder.sv
// Scoreboard bench: the same beat stream drives a 1-word-payload and a 2-word-payload
// decoder; a frame-level reference model predicts pulses and messages per instance.
module tb_rvvi_host_cmd_decoder;

    localparam int N   = 3;
    localparam int H   = 5;
    localparam int P1  = 1;
    localparam int P2  = 2;
    localparam int MW1 = N * P1 * 32;
    localparam int MW2 = N * P2 * 32;

    localparam logic [MW1-1:0] RST1 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    localparam logic [MW2-1:0] RST2 = {32'hBEEF_0021, 32'hBEEF_0020, 32'hBEEF_0011,
                                       32'hBEEF_0010, 32'hBEEF_0001, 32'hBEEF_0000};
    localparam logic [159:0] STR2  = 160'h6e69_6574_6172_005c_8f54_0000_1654_4502_1111_6843;
    localparam logic [159:0] STR01 = 160'h0bad_cafe_dead_beef_0123_4567_89ab_cdef_5a5a_a5a5;

    typedef logic [31:0] wq_t[$];
    typedef logic [3:0]  sq_t[$];
    typedef struct {
        int           cyc;
        logic [2:0]   hit;
        logic         bad;
        logic [191:0] msg;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [N*H*32-1:0] cs;
    logic [2:0]       en;
    logic [31:0]      rdata;
    logic [3:0]       rstrb;
    logic             rlast;
    logic             rvalid;
    logic [2:0]       hit1, hit2;
    logic             bad1, bad2;
    logic [MW1-1:0]   msg1;
    logic [MW2-1:0]   msg2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [191:0] mdl1 = {96'b0, RST1};
    logic [191:0] mdl2 = RST2;
    logic [191:0] cur1 = {96'b0, RST1};
    logic [191:0] cur2 = RST2;

    rvvi_host_cmd_decoder #(.NUM_CMDS(N), .HDR_WORDS(H), .PAYLOAD_WORDS(P1), .MSG_RESET(RST1)) dut1 (
        .clk(clk), .reset(reset), .CompareStrings(cs), .CmdEnable(en),
        .RvviAxiRdata(rdata), .RvviAxiRstrb(rstrb), .RvviAxiRlast(rlast), .RvviAxiRvalid(rvalid),
        .CmdHit(hit1), .CmdMessage(msg1), .BadFrame(bad1)
    );

    rvvi_host_cmd_decoder #(.NUM_CMDS(N), .HDR_WORDS(H), .PAYLOAD_WORDS(P2), .MSG_RESET(RST2)) dut2 (
        .clk(clk), .reset(reset), .CompareStrings(cs), .CmdEnable(en),
        .RvviAxiRdata(rdata), .RvviAxiRstrb(rstrb), .RvviAxiRlast(rlast), .RvviAxiRvalid(rvalid),
        .CmdHit(hit2), .CmdMessage(msg2), .BadFrame(bad2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decide a frame's outcome from the whole frame at once.
    task automatic model(input int p, input wq_t w, input sq_t s, input logic [2:0] e,
                         output int ev, output int ch, output logic [2:0] hit, output logic bad);
        logic [2:0] m;
        int len;
        len = w.size();
        ev = -1; ch = -1; hit = '0; bad = 1'b0;
        if (len <= H) return;
        m = e;
        for (int k = 0; k < H; k++)
            for (int c = 0; c < N; c++)
                if (s[k] != 4'hF || w[k] != cs[(c*H+k)*32 +: 32]) m[c] = 1'b0;
        if (m == '0) return;
        if (len - H >= p) begin
            ev = H + p - 1;
            for (int c = N - 1; c >= 0; c--) if (m[c]) ch = c;
            hit[ch] = 1'b1;
        end else begin
            ev  = len - 1;
            bad = 1'b1;
        end
    endtask

    task automatic apply(input int p, input int ch, input wq_t w, inout logic [191:0] m);
        if (ch >= 0)
            for (int k = 0; k < p; k++) m[(ch*p+k)*32 +: 32] = w[H+k];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'($urandom_range(1));
            rdata  = $urandom;
        end
    endtask

    task automatic hdr_of(input logic [159:0] str, output wq_t w, output sq_t s);
        w = {};
        s = {};
        for (int k = 0; k < H; k++) begin
            w.push_back(str[k*32 +: 32]);
            s.push_back(4'hF);
        end
    endtask

    task automatic send_frame(input wq_t w, input sq_t s, input logic [2:0] e,
                              input int gap_pct, input bit b2b);
        int ev1, ev2, ch1, ch2, ng;
        logic [2:0] h1, h2;
        logic b1, b2;
        if (!b2b) idle($urandom_range(1, 3));
        model(P1, w, s, e, ev1, ch1, h1, b1);
        model(P2, w, s, e, ev2, ch2, h2, b2);
        apply(P1, ch1, w, mdl1);
        apply(P2, ch2, w, mdl2);
        for (int i = 0; i < w.size(); i++) begin
            ng = 0;
            while (i > 0 && ng < 4 && $urandom_range(99) < gap_pct) begin
                idle(1);
                ng++;
            end
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = w[i];
            rstrb  = s[i];
            rlast  = (i == w.size() - 1);
            if (i == 0) en = e;
            if (i == ev1) q1.push_back('{cyc + 1, h1, b1, mdl1});
            if (i == ev2) q2.push_back('{cyc + 1, h2, b2, mdl2});
        end
    endtask

    // Monitor for the 1-word-payload instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cur1 = {96'b0, RST1};
        end else begin
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                check("dut1 missed pulse cycle", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
            if (hit1 != '0 || bad1) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected pulse", {hit1, bad1}, 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1 pulse cycle", cyc, e.cyc);
                    check("dut1 CmdHit", hit1, e.hit);
                    check("dut1 BadFrame", bad1, e.bad);
                    check("dut1 CmdMessage at pulse", msg1, e.msg);
                    cur1 = e.msg;
                end
            end else begin
                check("dut1 CmdMessage held", msg1, cur1);
            end
        end
    end

    // Monitor for the 2-word-payload instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cur2 = RST2;
        end else begin
            while (q2.size() > 0 && q2[0].cyc < cyc) begin
                check("dut2 missed pulse cycle", cyc, q2[0].cyc);
                void'(q2.pop_front());
            end
            if (hit2 != '0 || bad2) begin
                if (q2.size() == 0) begin
                    check("dut2 unexpected pulse", {hit2, bad2}, 0);
                end else begin
                    e = q2.pop_front();
                    check("dut2 pulse cycle", cyc, e.cyc);
                    check("dut2 CmdHit", hit2, e.hit);
                    check("dut2 BadFrame", bad2, e.bad);
                    check("dut2 CmdMessage at pulse", msg2, e.msg);
                    cur2 = e.msg;
                end
            end else begin
                check("dut2 CmdMessage held", msg2, cur2);
            end
        end
    end

    initial begin
        wq_t w;
        sq_t s;
        int  sel, len, idx;
        logic [159:0] base;

        reset  = 1'b1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
        rstrb  = 4'hF;
        en     = 3'b111;
        cs     = {STR2, STR01, STR01};
        #1;
        check("reset dut1 CmdHit", hit1, 0);
        check("reset dut1 BadFrame", bad1, 0);
        check("reset dut1 CmdMessage", msg1, RST1);
        check("reset dut2 CmdHit", hit2, 0);
        check("reset dut2 BadFrame", bad2, 0);
        check("reset dut2 CmdMessage", msg2, RST2);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Channel 2 match, one payload word with Rlast (short for the 2-word instance).
        hdr_of(STR2, w, s); w.push_back(32'h0000_0040); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        // Header word mismatch, then the same frame again back-to-back.
        hdr_of(STR2, w, s); w[1] = 32'h1654_4503; w.push_back(32'h0000_0040); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        hdr_of(STR2, w, s); w.push_back(32'h0000_0041); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 1);
        // Two payload words plus an extra trailing word.
        hdr_of(STR2, w, s);
        w.push_back(32'h1234_5678); w.push_back(32'h9abc_def0); w.push_back(32'h5555_aaaa);
        s.push_back(4'hF); s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        // Rlast on the final header word, and on an earlier header word.
        hdr_of(STR2, w, s);
        send_frame(w, s, 3'b111, 0, 0);
        hdr_of(STR2, w, s); w = w[0:2]; s = s[0:2];
        send_frame(w, s, 3'b111, 0, 0);
        // Shared string: priority, then enable masking.
        hdr_of(STR01, w, s); w.push_back(32'hAAAA_0000); w.push_back(32'hAAAA_0001);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        send_frame(w, s, 3'b110, 0, 0);
        send_frame(w, s, 3'b000, 0, 0);
        send_frame(w, s, 3'b100, 0, 0);
        // Valid gaps inside the frame.
        hdr_of(STR2, w, s); w.push_back(32'h0000_0077); w.push_back(32'h0000_0078);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 60, 0);
        // Back-to-back: channel 0 then channel 1 with no idle cycle.
        hdr_of(STR01, w, s); w.push_back(32'hB2B0_0000); w.push_back(32'hB2B0_0001);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        w[H] = 32'hB2B1_0000; w[H+1] = 32'hB2B1_0001;
        send_frame(w, s, 3'b110, 0, 1);
        // Partial strobe on a header word.
        hdr_of(STR2, w, s); s[2] = 4'h7; w.push_back(32'h0000_0099); w.push_back(32'h0000_009A);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);

        // Randomised traffic.
        for (int f = 0; f < 300; f++) begin
            sel = $urandom_range(2);
            base = (sel == 0) ? STR01 : STR2;
            len = $urandom_range(1, 9);
            w = {};
            s = {};
            for (int i = 0; i < len; i++) begin
                if (i < H && sel != 2) w.push_back(base[i*32 +: 32]);
                else                   w.push_back($urandom);
                s.push_back(4'hF);
            end
            if ($urandom_range(99) < 20) begin
                idx = $urandom_range(H - 1);
                if (idx < len) w[idx] = w[idx] ^ (32'h1 << $urandom_range(31));
            end
            if ($urandom_range(99) < 10) s[$urandom_range(len - 1)] = 4'($urandom_range(14));
            send_frame(w, s, ($urandom_range(1) != 0) ? 3'b111 : 3'($urandom_range(7)),
                       ($urandom_range(99) < 30) ? 30 : 0, $urandom_range(1) != 0);
        end
        idle(4);

        // Make sure channel 2 holds a committed value, then reset in the payload phase.
        hdr_of(STR2, w, s); w.push_back(32'h0C0C_0001); w.push_back(32'h0C0C_0002);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);
        idle(3);
        hdr_of(STR2, w, s);
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = w[i];
            rstrb  = 4'hF;
            rlast  = 1'b0;
        end
        @(negedge clk);
        rvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async reset dut1 CmdHit", hit1, 0);
        check("async reset dut1 BadFrame", bad1, 0);
        check("async reset dut1 CmdMessage", msg1, RST1);
        check("async reset dut2 CmdHit", hit2, 0);
        check("async reset dut2 BadFrame", bad2, 0);
        check("async reset dut2 CmdMessage", msg2, RST2);
        mdl1 = {96'b0, RST1};
        mdl2 = RST2;
        @(negedge clk);
        #2 reset = 1'b0;
        hdr_of(STR2, w, s); w.push_back(32'hAF7E_0001); w.push_back(32'hAF7E_0002);
        s.push_back(4'hF); s.push_back(4'hF);
        send_frame(w, s, 3'b111, 0, 0);

        idle(10);
        check("dut1 pending expectations", q1.size(), 0);
        check("dut2 pending expectations", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
